// File: rtl/irq_arbiter_pkg.sv
// Shared constants and types for the platform interrupt arbiter.
package irq_arbiter_pkg;

    localparam int unsigned IRQ_NUM_SRC = 10;
    localparam int unsigned IRQ_PRIO_W  = 3;
    localparam int unsigned IRQ_ADDR_W  = 8;

    localparam int unsigned IRQ_REG_ENABLE    = 'h00;
    localparam int unsigned IRQ_REG_PENDING   = 'h04;
    localparam int unsigned IRQ_REG_EDGE_SEL  = 'h08;
    localparam int unsigned IRQ_REG_THRESHOLD = 'h0C;
    localparam int unsigned IRQ_REG_CLAIM     = 'h10;
    localparam int unsigned IRQ_REG_PRIO_BASE = 'h40;

    // Source IDs in TRAP_CODE_* peripheral order; ID 0 means "none"
    localparam int unsigned IRQ_ID_UART0_RX = 1;
    localparam int unsigned IRQ_ID_UART0_TX = 2;
    localparam int unsigned IRQ_ID_TIMER0   = 3;
    localparam int unsigned IRQ_ID_TIMER1   = 4;
    localparam int unsigned IRQ_ID_GPIOA0   = 5;
    localparam int unsigned IRQ_ID_GPIOA1   = 6;
    localparam int unsigned IRQ_ID_GPIOB0   = 7;
    localparam int unsigned IRQ_ID_GPIOB1   = 8;
    localparam int unsigned IRQ_ID_GPIOC0   = 9;
    localparam int unsigned IRQ_ID_GPIOC1   = 10;

    typedef enum logic [1:0] {
        GW_IDLE  = 2'd0,
        GW_PEND  = 2'd1,
        GW_INSRV = 2'd2
    } irq_gw_state_t;

endpackage

// File: rtl/irq_arbiter_gateway.sv
// Per-source gateway: request detection, IDLE/PEND/INSRV tracking and a
// deferred bit for edges that arrive while the source is being serviced.
module irq_gateway
    import irq_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic edge_sel,
    input  logic claim,
    input  logic complete,
    output logic pend,
    output logic insrv
);

    irq_gw_state_t state;
    logic          src_q;
    logic          deferred;
    logic          rise;
    logic          req;

    assign rise = src & ~src_q;
    assign req  = edge_sel ? rise : src;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= GW_IDLE;
            src_q    <= 1'b0;
            deferred <= 1'b0;
            pend     <= 1'b0;
            insrv    <= 1'b0;
        end else begin
            src_q <= src;
            case (state)
                GW_IDLE: begin
                    if (req) begin
                        state <= GW_PEND;
                        pend  <= 1'b1;
                    end
                end
                // Further requests while pending are absorbed
                GW_PEND: begin
                    if (claim) begin
                        state <= GW_INSRV;
                        pend  <= 1'b0;
                        insrv <= 1'b1;
                    end
                end
                GW_INSRV: begin
                    if (complete) begin
                        insrv    <= 1'b0;
                        deferred <= 1'b0;
                        if (deferred || req) begin
                            state <= GW_PEND;
                            pend  <= 1'b1;
                        end else begin
                            state <= GW_IDLE;
                        end
                    end else if (edge_sel && rise) begin
                        deferred <= 1'b1;
                    end
                end
                default: begin
                    state <= GW_IDLE;
                    pend  <= 1'b0;
                    insrv <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Platform interrupt arbiter: register file, priority selection and the
// claim/complete handshake driving a single prioritised irq.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = IRQ_NUM_SRC,
    parameter int unsigned PRIO_W  = IRQ_PRIO_W,
    parameter int unsigned ADDR_W  = IRQ_ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0]             src,
    input  logic                           bus_rd_en,
    input  logic                           bus_wr_en,
    input  logic [ADDR_W-1:0]              bus_addr,
    input  logic [31:0]                    bus_wr_data,
    output logic [31:0]                    bus_rd_data,
    output logic                           irq,
    output logic [$clog2(NUM_SRC+1)-1:0]   irq_id
);

    localparam int unsigned ID_W = $clog2(NUM_SRC + 1);

    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] edge_sel_q;
    logic [PRIO_W-1:0]  threshold_q;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];

    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] insrv;
    logic [NUM_SRC-1:0] claim;
    logic [NUM_SRC-1:0] complete;

    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;

    logic               rd_claim;
    logic               wr_claim;
    logic               prio_hit;
    logic [ADDR_W-1:0]  prio_off;
    logic [ADDR_W-1:0]  prio_sel;
    logic [31:0]        rd_val;

    assign rd_claim = bus_rd_en && (bus_addr == ADDR_W'(IRQ_REG_CLAIM));
    assign wr_claim = bus_wr_en && (bus_addr == ADDR_W'(IRQ_REG_CLAIM));

    // Priority window decode: 0x40 + 4*id for id 1..NUM_SRC
    assign prio_off = bus_addr - ADDR_W'(IRQ_REG_PRIO_BASE);
    assign prio_sel = prio_off >> 2;
    assign prio_hit = (bus_addr[1:0] == 2'b00)
                   && (bus_addr > ADDR_W'(IRQ_REG_PRIO_BASE))
                   && (bus_addr <= ADDR_W'(IRQ_REG_PRIO_BASE + 4 * NUM_SRC));

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clk      (clk),
            .rst_n    (rst_n),
            .src      (src[g]),
            .edge_sel (edge_sel_q[g]),
            .claim    (claim[g]),
            .complete (complete[g]),
            .pend     (pend[g]),
            .insrv    (insrv[g])
        );
    end

    // Strict '>' keeps the lowest ID on a priority tie
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_prio  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend[i] && enable_q[i] && (prio_q[i] > threshold_q) && (prio_q[i] > win_prio)) begin
                win_valid = 1'b1;
                win_prio  = prio_q[i];
                win_id    = ID_W'(i + 1);
            end
        end
    end

    always_comb begin
        claim    = '0;
        complete = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim[i]    = rd_claim && win_valid && (win_id == ID_W'(i + 1));
            complete[i] = wr_claim && insrv[i] && (bus_wr_data == 32'(i + 1));
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus_addr)
            ADDR_W'(IRQ_REG_ENABLE):    rd_val = 32'({enable_q, 1'b0});
            ADDR_W'(IRQ_REG_PENDING):   rd_val = 32'({pend, 1'b0});
            ADDR_W'(IRQ_REG_EDGE_SEL):  rd_val = 32'({edge_sel_q, 1'b0});
            ADDR_W'(IRQ_REG_THRESHOLD): rd_val = 32'(threshold_q);
            ADDR_W'(IRQ_REG_CLAIM):     rd_val = 32'(win_id);
            default:                    rd_val = '0;
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            if (prio_hit && (prio_sel == ADDR_W'(i + 1))) begin
                rd_val = 32'(prio_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_q    <= '0;
            edge_sel_q  <= '1;
            threshold_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio_q[i] <= '0;
            end
            irq         <= 1'b0;
            irq_id      <= '0;
            bus_rd_data <= '0;
        end else begin
            irq    <= win_valid;
            irq_id <= win_id;
            if (bus_rd_en) begin
                bus_rd_data <= rd_val;
            end
            if (bus_wr_en) begin
                case (bus_addr)
                    ADDR_W'(IRQ_REG_ENABLE):    enable_q    <= bus_wr_data[NUM_SRC:1];
                    ADDR_W'(IRQ_REG_EDGE_SEL):  edge_sel_q  <= bus_wr_data[NUM_SRC:1];
                    ADDR_W'(IRQ_REG_THRESHOLD): threshold_q <= bus_wr_data[PRIO_W-1:0];
                    default: ;
                endcase
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (prio_hit && (prio_sel == ADDR_W'(i + 1))) begin
                        prio_q[i] <= bus_wr_data[PRIO_W-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter; register reads are scored through a queue.
module tb_irq_arbiter;

    logic        clk;
    logic        rst_n;
    logic [9:0]  src;
    logic        bus_rd_en;
    logic        bus_wr_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        irq;
    logic [3:0]  irq_id;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    irq_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src         (src),
        .bus_rd_en   (bus_rd_en),
        .bus_wr_en   (bus_wr_en),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .irq         (irq),
        .irq_id      (irq_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] prio_addr(input int id);
        return 8'(8'h40 + 4 * id);
    endfunction

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus_wr_en   = 1'b1;
        bus_addr    = a;
        bus_wr_data = d;
        tick();
        bus_wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
        exp_t x;
        x.tag = tag;
        x.val = e;
        sb.push_back(x);
        bus_rd_en = 1'b1;
        bus_addr  = a;
        tick();
        bus_rd_en = 1'b0;
        x = sb.pop_front();
        check(x.tag, bus_rd_data, x.val);
    endtask

    task automatic pulse(input int idx);
        src[idx] = 1'b1;
        tick();
        src[idx] = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        src         = '0;
        bus_rd_en   = 1'b0;
        bus_wr_en   = 1'b0;
        bus_addr    = '0;
        bus_wr_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("irq_reset", 32'(irq), 32'h0);
        check("irq_id_reset", 32'(irq_id), 32'h0);
        check("rd_data_reset", bus_rd_data, 32'h0);
        rd(8'h00, 32'h0, "enable_reset");
        rd(8'h04, 32'h0, "pending_reset");
        rd(8'h08, 32'h7FE, "edge_sel_reset");
        rd(8'h0C, 32'h0, "threshold_reset");
        rd(8'h10, 32'h0, "claim_reset");
        rd(prio_addr(1), 32'h0, "prio1_reset");
        rd(8'h20, 32'h0, "unmapped_read");

        // Single edge source ID3
        wr(prio_addr(3), 32'd2);
        rd(prio_addr(3), 32'd2, "prio3_readback");
        wr(8'h00, 32'h8);
        pulse(2);
        check("irq_latency", 32'(irq), 32'h0);
        rd(8'h04, 32'h8, "pending_id3");
        check("irq_id3", 32'(irq), 32'h1);
        check("irq_id_id3", 32'(irq_id), 32'h3);
        rd(8'h10, 32'd3, "claim_id3");
        rd(8'h04, 32'h0, "pending_after_claim");
        check("irq_after_claim", 32'(irq), 32'h0);
        wr(8'h10, 32'd3);
        pulse(2);
        rd(8'h04, 32'h8, "repend_id3");
        rd(8'h10, 32'd3, "reclaim_id3");
        wr(8'h10, 32'd3);

        // Tie goes to lowest ID, then higher priority wins
        wr(prio_addr(2), 32'd4);
        wr(prio_addr(5), 32'd4);
        wr(8'h00, 32'h2C);
        src[1] = 1'b1;
        src[4] = 1'b1;
        tick();
        src = '0;
        rd(8'h10, 32'd2, "claim_tie");
        check("irq_id_tie", 32'(irq_id), 32'h2);
        wr(8'h10, 32'd2);
        wr(prio_addr(5), 32'd6);
        pulse(1);
        rd(8'h10, 32'd5, "claim_prio");
        wr(8'h10, 32'd5);
        rd(8'h10, 32'd2, "claim_id2");
        wr(8'h10, 32'd2);

        // Threshold masking
        wr(8'h00, 32'h2);
        wr(prio_addr(1), 32'd3);
        wr(8'h0C, 32'd3);
        pulse(0);
        tick();
        check("irq_thr_masked", 32'(irq), 32'h0);
        rd(8'h04, 32'h2, "pending_thr");
        wr(8'h0C, 32'd2);
        check("irq_thr_old", 32'(irq), 32'h0);
        tick();
        check("irq_thr_open", 32'(irq), 32'h1);
        check("irq_id_thr", 32'(irq_id), 32'h1);
        rd(8'h10, 32'd1, "claim_id1");
        wr(8'h10, 32'd1);
        wr(8'h0C, 32'd0);

        // Deferred edge during service
        wr(8'h00, 32'h10);
        wr(prio_addr(4), 32'd1);
        pulse(3);
        rd(8'h10, 32'd4, "claim_id4");
        pulse(3);
        tick();
        check("irq_deferred", 32'(irq), 32'h0);
        rd(8'h04, 32'h0, "pending_deferred");
        wr(8'h10, 32'd4);
        rd(8'h04, 32'h10, "pending_after_complete");
        check("irq_after_complete", 32'(irq), 32'h1);
        rd(8'h10, 32'd4, "claim_id4_again");
        wr(8'h10, 32'd4);

        // Level source held high through complete
        wr(8'h08, 32'h7BE);
        wr(prio_addr(6), 32'd2);
        wr(8'h00, 32'h40);
        src[5] = 1'b1;
        tick();
        tick();
        rd(8'h10, 32'd6, "claim_level");
        wr(8'h10, 32'd6);
        rd(8'h04, 32'h40, "level_repend");
        src[5] = 1'b0;
        rd(8'h10, 32'd6, "claim_level_again");
        wr(8'h10, 32'd6);
        rd(8'h04, 32'h0, "level_idle");
        wr(8'h08, 32'h7FE);

        // Bogus completes and empty claim
        wr(8'h00, 32'h10);
        pulse(3);
        rd(8'h10, 32'd4, "claim_id4_b");
        wr(8'h10, 32'd0);
        wr(8'h10, 32'd11);
        wr(8'h10, 32'd5);
        rd(8'h10, 32'd0, "claim_none");
        check("irq_none", 32'(irq), 32'h0);
        pulse(3);
        rd(8'h04, 32'h0, "bogus_no_release");
        wr(8'h00, 32'h18);
        pulse(2);
        rd(8'h04, 32'h8, "pending_pre_reset");
        check("irq_pre_reset", 32'(irq), 32'h1);

        // Reset while ID4 in service and ID3 pending
        rst_n = 1'b0;
        tick();
        check("irq_mid_reset", 32'(irq), 32'h0);
        check("irq_id_mid_reset", 32'(irq_id), 32'h0);
        check("rd_data_mid_reset", bus_rd_data, 32'h0);
        rst_n = 1'b1;
        rd(8'h00, 32'h0, "enable_after_reset");
        rd(8'h04, 32'h0, "pending_after_reset");
        rd(prio_addr(3), 32'h0, "prio3_after_reset");
        rd(8'h08, 32'h7FE, "edge_sel_after_reset");
        wr(8'h00, 32'h10);
        wr(prio_addr(4), 32'd1);
        pulse(3);
        rd(8'h04, 32'h10, "id4_idle_after_reset");

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
